// File: rtl/weapons_control_unit_pkg.sv
// Shared definitions for the weapons control unit: state encodings and
// the default missile capacity.
package weapons_control_unit_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    TARGET_LOCK = 2'b01,
    FIRE        = 2'b10,
    OUT_OF_AMMO = 2'b11
  } wcu_state_t;

  // Missile load restored on every reset unless overridden.
  localparam int DEFAULT_MAX_MISSILES = 4;

  // Width of the on-board missile count (holds 0..15).
  localparam int COUNT_W = 4;

endpackage

// File: rtl/wcu_missile_counter.sv
// Missile counter: loads the full magazine on reset, counts down one per
// launch and flags the empty and last-missile conditions for the FSM.
module wcu_missile_counter
  import weapons_control_unit_pkg::*;
#(
  parameter int MAX_MISSILES = DEFAULT_MAX_MISSILES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_en,
  output logic [COUNT_W-1:0] count,
  output logic               count_zero,
  output logic               count_last
);

  logic [COUNT_W-1:0] count_reg;

  // Full load while reset is held; saturating decrement on each launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= COUNT_W'(MAX_MISSILES);
    end else if (dec_en && (count_reg != '0)) begin
      count_reg <= count_reg - COUNT_W'(1);
    end
  end

  // Status flags derived from the registered count.
  always_comb begin
    count      = count_reg;
    count_zero = (count_reg == '0);
    count_last = (count_reg == COUNT_W'(1));
  end

endmodule

// File: rtl/weapons_control_unit.sv
// Weapons control unit: tracks target lock, releases one missile per fire
// request while locked, and parks in OUT_OF_AMMO once the magazine is empty.
module weapons_control_unit
  import weapons_control_unit_pkg::*;
#(
  parameter int MAX_MISSILES = DEFAULT_MAX_MISSILES
) (
  input  logic       target_locked,
  input  logic       clk,
  input  logic       rst,
  input  logic       fire_command,
  output logic       launch_missile,
  output logic [3:0] remaining_missiles,
  output logic [1:0] WCU_state
);

  wcu_state_t         state_reg;
  wcu_state_t         state_next;
  logic               dec_en;
  logic [COUNT_W-1:0] count;
  logic               count_zero;
  logic               count_last;

  wcu_missile_counter #(
    .MAX_MISSILES (MAX_MISSILES)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .dec_en     (dec_en),
    .count      (count),
    .count_zero (count_zero),
    .count_last (count_last)
  );

  // State register; an asynchronous reset also aborts any launch in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Leaving FIRE, the count about to be decremented
  // decides between OUT_OF_AMMO and a return to lock/idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (target_locked) state_next = TARGET_LOCK;
      end
      TARGET_LOCK: begin
        if (!target_locked) begin
          state_next = IDLE;
        end else if (fire_command && !count_zero) begin
          state_next = FIRE;
        end
      end
      FIRE: begin
        if (count_last) begin
          state_next = OUT_OF_AMMO;
        end else if (target_locked) begin
          state_next = TARGET_LOCK;
        end else begin
          state_next = IDLE;
        end
      end
      OUT_OF_AMMO: begin
        state_next = OUT_OF_AMMO;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore output decode; the launch cycle also drives the count-down.
  always_comb begin
    launch_missile     = (state_reg == FIRE);
    dec_en             = (state_reg == FIRE);
    remaining_missiles = count;
    WCU_state          = state_reg;
  end

endmodule

// File: tb/tb_weapons_control_unit.sv
// Self-checking bench for weapons_control_unit against a rule-level model.
module tb_weapons_control_unit;

  localparam int MAXM = 4;

  logic       clk;
  logic       rst;
  logic       target_locked;
  logic       fire_command;
  logic       launch_missile;
  logic [3:0] remaining_missiles;
  logic [1:0] WCU_state;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle, 1=locked, 2=firing, 3=empty; missiles left.
  int m_mode  = 0;
  int m_left  = MAXM;
  int m_shots = 0;

  weapons_control_unit #(.MAX_MISSILES(MAXM)) dut (
    .target_locked      (target_locked),
    .clk                (clk),
    .rst                (rst),
    .fire_command       (fire_command),
    .launch_missile     (launch_missile),
    .remaining_missiles (remaining_missiles),
    .WCU_state          (WCU_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by the rules for one edge, then let the DUT take the edge.
  task automatic tick();
    int nm;
    int nl;
    nm = m_mode;
    nl = m_left;
    if (m_mode == 0) begin
      nm = target_locked ? 1 : 0;
    end else if (m_mode == 1) begin
      if (!target_locked)                  nm = 0;
      else if (fire_command && m_left > 0) nm = 2;
    end else if (m_mode == 2) begin
      nl = m_left - 1;
      m_shots++;
      if (nl == 0)            nm = 3;
      else if (target_locked) nm = 1;
      else                    nm = 0;
    end
    m_mode = nm;
    m_left = nl;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle reset pulse; leaves time at least 3 units before the next edge.
  task automatic do_reset();
    target_locked = 1'b0;
    fire_command  = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    m_mode  = 0;
    m_left  = MAXM;
    m_shots = 0;
  endtask

  task automatic test_reset();
    target_locked = 1'b0;
    fire_command  = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({WCU_state, remaining_missiles, launch_missile} !== {2'b00, 4'd4, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold: state=%b count=%0d launch=%b, want 00/4/0",
                 WCU_state, remaining_missiles, launch_missile);
      end
    end
    #2;
    rst = 1'b1;
    m_mode = 0; m_left = MAXM; m_shots = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({WCU_state, remaining_missiles, launch_missile} !== {2'b00, 4'd4, 1'b0}) begin
        errors++;
        $display("FAIL reset_release cyc%0d: state=%b count=%0d launch=%b, want 00/4/0",
                 i, WCU_state, remaining_missiles, launch_missile);
      end
    end
  endtask

  task automatic test_lock_unlock();
    logic [1:0] want [3] = '{2'b01, 2'b01, 2'b00};
    do_reset();
    target_locked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) target_locked = 1'b0;
      tick();
      checks++;
      if ({WCU_state, remaining_missiles, launch_missile} !== {want[i], 4'd4, 1'b0}) begin
        errors++;
        $display("FAIL lock_unlock cyc%0d: state=%b count=%0d launch=%b, want %b/4/0",
                 i, WCU_state, remaining_missiles, launch_missile, want[i]);
      end
    end
  endtask

  task automatic test_single_fire();
    do_reset();
    target_locked = 1'b1;
    tick();
    fire_command = 1'b1;
    tick();
    checks++;
    if ({WCU_state, remaining_missiles, launch_missile} !== {2'b10, 4'd4, 1'b1}) begin
      errors++;
      $display("FAIL single_fire_launch: state=%b count=%0d launch=%b, want 10/4/1",
               WCU_state, remaining_missiles, launch_missile);
    end
    fire_command = 1'b0;
    tick();
    checks++;
    if ({WCU_state, remaining_missiles, launch_missile} !== {2'b01, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL single_fire_after: state=%b count=%0d launch=%b, want 01/3/0",
               WCU_state, remaining_missiles, launch_missile);
    end
  endtask

  task automatic test_continuous_and_abort();
    int launches = 0;
    do_reset();
    target_locked = 1'b1;
    fire_command  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (launch_missile === 1'b1) launches++;
      checks++;
      if (WCU_state !== 2'(m_mode) || remaining_missiles !== 4'(m_left) ||
          launch_missile !== (m_mode == 2)) begin
        errors++;
        $display("FAIL continuous cyc%0d: state=%b count=%0d launch=%b, want %0d/%0d/%0d",
                 i, WCU_state, remaining_missiles, launch_missile, m_mode, m_left, m_mode == 2);
      end
    end
    checks++;
    if (launches != MAXM || WCU_state !== 2'b11 || remaining_missiles !== 4'd0) begin
      errors++;
      $display("FAIL continuous_total: launches=%0d state=%b count=%0d, want %0d/11/0",
               launches, WCU_state, remaining_missiles, MAXM);
    end
    // Asynchronous reset out of OUT_OF_AMMO, observed before any edge.
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({WCU_state, remaining_missiles, launch_missile} !== {2'b00, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_empty: state=%b count=%0d launch=%b, want 00/4/0",
               WCU_state, remaining_missiles, launch_missile);
    end
    rst = 1'b1;
    target_locked = 1'b0;
    fire_command  = 1'b0;
    m_mode = 0; m_left = MAXM; m_shots = 0;
    // Asynchronous reset during FIRE: the launch is not counted.
    target_locked = 1'b1;
    tick();
    fire_command = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({WCU_state, remaining_missiles, launch_missile} !== {2'b00, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_fire: state=%b count=%0d launch=%b, want 00/4/0",
               WCU_state, remaining_missiles, launch_missile);
    end
    target_locked = 1'b0;
    fire_command  = 1'b0;
    rst = 1'b1;
    m_mode = 0; m_left = MAXM; m_shots = 0;
    tick();
    checks++;
    if ({WCU_state, remaining_missiles} !== {2'b00, 4'd4}) begin
      errors++;
      $display("FAIL post_abort: state=%b count=%0d, want 00/4", WCU_state, remaining_missiles);
    end
  endtask

  task automatic test_drop_in_fire();
    do_reset();
    target_locked = 1'b1;
    tick();
    fire_command = 1'b1;
    tick();
    target_locked = 1'b0;
    fire_command  = 1'b0;
    tick();
    checks++;
    if ({WCU_state, remaining_missiles, launch_missile} !== {2'b00, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL drop_in_fire: state=%b count=%0d launch=%b, want 00/3/0",
               WCU_state, remaining_missiles, launch_missile);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    tick();
    #2;
    target_locked = 1'b1;
    #3;
    target_locked = 1'b0;
    tick();
    checks++;
    if (WCU_state !== 2'b00) begin
      errors++;
      $display("FAIL glitch_ignored: state=%b, want 00", WCU_state);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      target_locked = ($urandom_range(0, 3) != 0);
      fire_command  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 59) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        m_mode = 0; m_left = MAXM;
      end
      tick();
      checks++;
      if (WCU_state !== 2'(m_mode) || remaining_missiles !== 4'(m_left) ||
          launch_missile !== (m_mode == 2)) begin
        errors++;
        $display("FAIL random cyc%0d: state=%b count=%0d launch=%b, want %0d/%0d/%0d",
                 i, WCU_state, remaining_missiles, launch_missile, m_mode, m_left, m_mode == 2);
      end
    end
  endtask

  initial begin
    target_locked = 1'b0;
    fire_command  = 1'b0;
    rst = 1'b1;
    test_reset();
    test_lock_unlock();
    test_single_fire();
    test_continuous_and_abort();
    test_drop_in_fire();
    test_glitch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weapons_control_unit.md
WEAPONS_CONTROL_UNIT -- requirements
Module: weapons_control_unit

Interface
REQ-001 The block SHALL have parameter MAX_MISSILES, default 4, giving the missile load after reset (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port target_locked, input, 1 bit: high while the sensor holds a lock on a target.
REQ-005 The block SHALL have port fire_command, input, 1 bit: operator fire request, level-sensitive.
REQ-006 The block SHALL have port launch_missile, output, 1 bit: high for exactly one clock cycle per missile released.
REQ-007 The block SHALL have port remaining_missiles, output, 4 bits, unsigned: missiles still on board.
REQ-008 The block SHALL have port WCU_state, output, 2 bits: current FSM state encoding.
REQ-009 The block SHALL keep the port order target_locked, clk, rst, fire_command, launch_missile, remaining_missiles, WCU_state, so positional instantiation works.

Function
REQ-010 The FSM SHALL have four states: IDLE=2'b00, TARGET_LOCK=2'b01, FIRE=2'b10, OUT_OF_AMMO=2'b11.
REQ-011 WCU_state SHALL always show the registered current state.
REQ-012 Transitions from IDLE SHALL be: go to TARGET_LOCK when target_locked=1; otherwise stay in IDLE. fire_command is ignored in IDLE.
REQ-013 Transitions from TARGET_LOCK SHALL be, in priority order:
- target_locked=0 -> IDLE;
- fire_command=1 and remaining_missiles>0 -> FIRE;
- otherwise stay in TARGET_LOCK.
REQ-014 FIRE SHALL last exactly one cycle. launch_missile SHALL be 1 in FIRE and 0 in every other state (Moore output).
REQ-015 On the clock edge leaving FIRE, remaining_missiles SHALL decrement by exactly 1.
REQ-016 The next state from FIRE SHALL be:
- OUT_OF_AMMO if the decremented count is 0;
- else TARGET_LOCK if target_locked=1;
- else IDLE.
REQ-017 OUT_OF_AMMO SHALL be absorbing until reset: launch_missile=0, remaining_missiles=0, all inputs ignored.
REQ-018 With target_locked and fire_command both held high, the block SHALL fire once every 2 cycles (TARGET_LOCK, FIRE, TARGET_LOCK, FIRE, ...) until empty.
REQ-019 remaining_missiles SHALL never wrap below 0 and SHALL never be incremented.
REQ-020 If target_locked drops during FIRE, the launch SHALL still complete and be counted.
REQ-021 Inputs SHALL be sampled only at rising clock edges; pulses between edges have no effect.

Reset
REQ-022 While rst=0, the block SHALL asynchronously force WCU_state=IDLE, remaining_missiles=MAX_MISSILES and launch_missile=0.
REQ-023 Assertion of rst mid-operation, including during FIRE or OUT_OF_AMMO, SHALL immediately abort the operation and restore the full load; a FIRE aborted this way SHALL NOT be counted.
REQ-024 After rst is released (goes high), the first state change SHALL occur on the next rising edge of clk.

Structure
REQ-025 A shared package SHALL hold the state encodings (IDLE, TARGET_LOCK, FIRE, OUT_OF_AMMO), the 2-bit state type, and the default missile capacity 4.
REQ-026 The missile counter (load on reset, decrement enable, zero flag) SHALL be one sub-module named wcu_missile_counter. The FSM and output decode SHALL remain in weapons_control_unit.

Verification
REQ-027 Reset held, then released, with target_locked=0 and fire_command=0 -> WCU_state=00, remaining_missiles=4, launch_missile=0 on every cycle.
REQ-028 Assert target_locked=1 for 2 cycles, then 0 -> 01 on the first edge after assertion, then back to 00. No launch; count stays 4.
REQ-029 In TARGET_LOCK, assert fire_command=1 for one cycle -> WCU_state=10 and launch_missile=1 for one cycle, then remaining_missiles=3 and state 01.
REQ-030 Hold target_locked=1 and fire_command=1 continuously -> launch pulses every 2 cycles with the count going 4,3,2,1,0, then WCU_state=11 with launch_missile=0 thereafter.
REQ-031 Drop target_locked in the cycle the FSM is in FIRE -> launch completes, count decrements, next state 00.
REQ-032 Assert rst=0 while in OUT_OF_AMMO or FIRE, between clock edges -> outputs go immediately to 00 / 4 / 0 without waiting for a clock edge.
